// File: rtl/hycontrol_pkg.sv
// Shared definitions for the HY packet sequencer and its 32x8 packet buffer.
package hycontrol_pkg;
   localparam int HY_BUF_DEPTH = 32;
   localparam int HY_ADDR_W    = 5;
   localparam int HY_PTR_W     = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_DISCARD = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_OUT     = 3'd5
   } hy_state_e;

   // Pointers carry one extra bit so a full 32-byte length is representable.
   function automatic logic [HY_ADDR_W-1:0] ptr_to_addr(input logic [HY_PTR_W-1:0] ptr);
      return ptr[HY_ADDR_W-1:0];
   endfunction
endpackage

// File: rtl/hycontrol_buffer.sv
// 32x8 HY packet buffer: registered write, read data follows the registered
// address so it is usable one clock after the sequencer issues the read.
module hycontrol_buffer
   import hycontrol_pkg::*;
(
   input  logic                 clk,
   input  logic [HY_ADDR_W-1:0] addr_i,
   input  logic [7:0]           dat_i,
   input  logic                 write_i,
   input  logic                 read_i,
   output logic [7:0]           dat_o
);

   logic [7:0] mem_q [HY_BUF_DEPTH];

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (write_i) begin
         mem_q[addr_i] <= dat_i;
      end
   end

   assign dat_o = read_i ? mem_q[addr_i] : 8'h00;

endmodule

// File: rtl/hycontrol_sequencer.sv
// Captures one HY command packet from AXI-stream into the buffer, then
// replays it byte-by-byte with framing; oversize packets are dropped whole.
module hycontrol_sequencer
   import hycontrol_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [HY_ADDR_W-1:0] buf_addr,
   output logic [7:0]           buf_dat_o,
   output logic                 buf_write,
   output logic                 buf_read,
   input  logic [7:0]           buf_dat_i,
   output logic [7:0]           m_data,
   output logic                 m_valid,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 pkt_drop,
   output logic [CNT_W-1:0]     pkt_ok_cnt,
   output logic [CNT_W-1:0]     pkt_drop_cnt
);

   localparam logic [HY_PTR_W-1:0] MAX_LEN_P = HY_PTR_W'(MAX_LEN);
   localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   hy_state_e            state_q, state_d;
   logic [HY_PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d, len_q, len_d;
   logic [HY_ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [7:0]           buf_dat_q, buf_dat_d, m_data_q, m_data_d;
   logic                 buf_write_q, buf_write_d, buf_read_q, buf_read_d;
   logic                 m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic                 pkt_drop_q, pkt_drop_d;
   logic [CNT_W-1:0]     ok_cnt_q, ok_cnt_d, drop_cnt_q, drop_cnt_d;
   logic                 beat_s;

   assign s_axis_tready = rst_n & ((state_q == ST_IDLE) | (state_q == ST_FILL) |
                                   (state_q == ST_DISCARD));
   assign beat_s        = s_axis_tvalid & s_axis_tready;
   assign busy          = (state_q != ST_IDLE);

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      rp_d        = rp_q;
      len_d       = len_q;
      buf_addr_d  = buf_addr_q;
      buf_dat_d   = buf_dat_q;
      buf_write_d = 1'b0;
      buf_read_d  = 1'b0;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      pkt_drop_d  = 1'b0;
      ok_cnt_d    = ok_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (beat_s) begin
               buf_write_d = 1'b1;
               buf_addr_d  = {HY_ADDR_W{1'b0}};
               buf_dat_d   = s_axis_tdata;
               if (s_axis_tlast) begin
                  len_d   = 6'd1;
                  rp_d    = 6'd0;
                  state_d = ST_RD_ADDR;
               end else begin
                  wp_d    = 6'd1;
                  state_d = ST_FILL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (beat_s) begin
               if (wp_q == MAX_LEN_P) begin
                  if (s_axis_tlast) begin
                     pkt_drop_d = 1'b1;
                     drop_cnt_d = drop_cnt_q + CNT_ONE;
                     state_d    = ST_IDLE;
                  end else begin
                     state_d = ST_DISCARD;
                  end
               end else begin
                  buf_write_d = 1'b1;
                  buf_addr_d  = ptr_to_addr(wp_q);
                  buf_dat_d   = s_axis_tdata;
                  wp_d        = wp_q + 6'd1;
                  if (s_axis_tlast) begin
                     len_d   = wp_q + 6'd1;
                     rp_d    = 6'd0;
                     state_d = ST_RD_ADDR;
                  end else begin
                     state_d = ST_FILL;
                  end
               end
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_DISCARD: begin
            if (beat_s && s_axis_tlast) begin
               pkt_drop_d = 1'b1;
               drop_cnt_d = drop_cnt_q + CNT_ONE;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_DISCARD;
            end
         end
         // The cycle spent here also lets a final write commit before the read.
         ST_RD_ADDR: begin
            buf_addr_d = ptr_to_addr(rp_q);
            buf_read_d = 1'b1;
            state_d    = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            m_data_d  = buf_dat_i;
            m_valid_d = 1'b1;
            m_last_d  = (rp_q == (len_q - 6'd1));
            state_d   = ST_OUT;
         end
         ST_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (m_last_q) begin
                  ok_cnt_d = ok_cnt_q + CNT_ONE;
                  state_d  = ST_IDLE;
               end else begin
                  rp_d    = rp_q + 6'd1;
                  state_d = ST_RD_ADDR;
               end
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wp_q        <= 6'd0;
         rp_q        <= 6'd0;
         len_q       <= 6'd0;
         buf_addr_q  <= {HY_ADDR_W{1'b0}};
         buf_dat_q   <= 8'h00;
         buf_write_q <= 1'b0;
         buf_read_q  <= 1'b0;
         m_data_q    <= 8'h00;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         pkt_drop_q  <= 1'b0;
         ok_cnt_q    <= {CNT_W{1'b0}};
         drop_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         len_q       <= len_d;
         buf_addr_q  <= buf_addr_d;
         buf_dat_q   <= buf_dat_d;
         buf_write_q <= buf_write_d;
         buf_read_q  <= buf_read_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         pkt_drop_q  <= pkt_drop_d;
         ok_cnt_q    <= ok_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign buf_addr     = buf_addr_q;
   assign buf_dat_o    = buf_dat_q;
   assign buf_write    = buf_write_q;
   assign buf_read     = buf_read_q;
   assign m_data       = m_data_q;
   assign m_valid      = m_valid_q;
   assign m_last       = m_last_q;
   assign pkt_drop     = pkt_drop_q;
   assign pkt_ok_cnt   = ok_cnt_q;
   assign pkt_drop_cnt = drop_cnt_q;

endmodule
